// File: rtl/miner_job_dispatcher_if.sv
`default_nettype none
// ============================================================================
//  Module      : miner_job_dispatcher_if
//  Description : Signal bundle around the mining job dispatcher.
//                Job channel   : job_valid/job_ready handshake carrying
//                                midstate, header tail, nonce range and tag.
//                Core channel  : midstate_vw, work_data, nonce_min/max and
//                                core_reset towards the SHA-256d core;
//                                is_golden_ticket/golden_nonce back from it.
//                Result channel: res_valid/res_ready handshake carrying
//                                res_found, res_nonce, res_job_id; plus busy.
//                Modport slave  = the dispatcher.
//                Modport master = its environment (job source, core and
//                                 result sink).
//  Revision    : 1.0 - initial release
// ============================================================================
interface miner_job_dispatcher_if;
    // job channel
    logic         job_valid;
    logic         job_ready;
    logic [255:0] job_midstate;
    logic [95:0]  job_data;
    logic [31:0]  job_nonce_min;
    logic [31:0]  job_nonce_max;
    logic [7:0]   job_id;
    // core channel
    logic [255:0] midstate_vw;
    logic [95:0]  work_data;
    logic [31:0]  nonce_min;
    logic [31:0]  nonce_max;
    logic         core_reset;
    logic         is_golden_ticket;
    logic [31:0]  golden_nonce;
    // result channel
    logic         res_valid;
    logic         res_ready;
    logic         res_found;
    logic [31:0]  res_nonce;
    logic [7:0]   res_job_id;
    logic         busy;

    modport slave (
        input  job_valid, job_midstate, job_data, job_nonce_min,
               job_nonce_max, job_id, is_golden_ticket, golden_nonce,
               res_ready,
        output job_ready, midstate_vw, work_data, nonce_min, nonce_max,
               core_reset, res_valid, res_found, res_nonce, res_job_id, busy
    );

    modport master (
        output job_valid, job_midstate, job_data, job_nonce_min,
               job_nonce_max, job_id, is_golden_ticket, golden_nonce,
               res_ready,
        input  job_ready, midstate_vw, work_data, nonce_min, nonce_max,
               core_reset, res_valid, res_found, res_nonce, res_job_id, busy
    );
endinterface
`default_nettype wire

// File: rtl/miner_job_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module      : miner_job_dispatcher
//  Description : Double-buffered job dispatcher in front of a SHA-256d
//                mining core. Holds one active job (driven to the core) and
//                one pending job, launches each job with a one-cycle
//                core_reset pulse, then ends it either on the golden-ticket
//                flag (after the pipeline-fill blank window) or when the
//                nonce-range cycle budget is used up, and reports one result
//                per job.
//  Ports       : hash_clk - clock, rising edge
//                reset_n  - synchronous active-low reset
//                bus      - miner_job_dispatcher_if.slave (job, core and
//                           result channels, busy)
//  Parameters  : LOOP_LOG2 - core unroll setting, LOOP = 1 << LOOP_LOG2
//                BLANK     - cycles after launch with golden flag ignored
//  Revision    : 1.0 - initial release
// ============================================================================
module miner_job_dispatcher #(
    parameter int LOOP_LOG2 = 1,
    parameter int BLANK     = 128
) (
    input  logic                    hash_clk,
    input  logic                    reset_n,
    miner_job_dispatcher_if.slave   bus
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_START   = 3'd1;
    localparam logic [2:0] S_RUN     = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_REPORT  = 3'd4;

    localparam logic [39:0] BLANK_W = 40'(BLANK);

    logic [2:0]   state_q, state_d;

    // active job (drives the core)
    logic [255:0] act_mid_q;
    logic [95:0]  act_data_q;
    logic [31:0]  act_min_q;
    logic [31:0]  act_max_q;
    logic [7:0]   act_id_q;

    // pending job
    logic [255:0] pend_mid_q;
    logic [95:0]  pend_data_q;
    logic [31:0]  pend_min_q;
    logic [31:0]  pend_max_q;
    logic [7:0]   pend_id_q;
    logic         pend_valid_q;

    logic [39:0]  run_cnt_q;
    logic [39:0]  budget_q;
    logic         res_found_q;
    logic [31:0]  res_nonce_q;

    logic         w_accept;
    logic         w_load_job;
    logic         w_load_pend;
    logic         w_pend_write;
    logic [39:0]  w_span;
    logic [39:0]  w_budget;
    logic         w_hit;

    assign w_accept     = bus.job_valid & ~pend_valid_q;
    // Outside IDLE every accepted job is parked in the pending slot.
    assign w_pend_write = w_accept & (state_q != S_IDLE);

    // Range size wraps modulo 2^32 and is then widened, so the full range
    // 0..FFFFFFFF yields 2^32 nonces without overflowing the 40-bit budget.
    assign w_span   = {8'd0, (act_max_q - act_min_q)} + 40'd1;
    assign w_budget = (w_span << LOOP_LOG2) + BLANK_W + 40'd2;

    assign w_hit = (bus.golden_nonce >= act_min_q) &&
                   (bus.golden_nonce <= act_max_q);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge hash_clk) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            act_mid_q    <= '0;
            act_data_q   <= '0;
            act_min_q    <= '0;
            act_max_q    <= '0;
            act_id_q     <= '0;
            pend_mid_q   <= '0;
            pend_data_q  <= '0;
            pend_min_q   <= '0;
            pend_max_q   <= '0;
            pend_id_q    <= '0;
            pend_valid_q <= 1'b0;
            run_cnt_q    <= '0;
            budget_q     <= '0;
            res_found_q  <= 1'b0;
            res_nonce_q  <= '0;
        end else begin
            state_q <= state_d;

            if (w_load_job) begin
                act_mid_q  <= bus.job_midstate;
                act_data_q <= bus.job_data;
                act_min_q  <= bus.job_nonce_min;
                act_max_q  <= bus.job_nonce_max;
                act_id_q   <= bus.job_id;
            end else if (w_load_pend) begin
                act_mid_q  <= pend_mid_q;
                act_data_q <= pend_data_q;
                act_min_q  <= pend_min_q;
                act_max_q  <= pend_max_q;
                act_id_q   <= pend_id_q;
            end

            // A write needs an empty slot, so it never collides with the
            // slot being drained into the active registers.
            if (w_pend_write) begin
                pend_mid_q   <= bus.job_midstate;
                pend_data_q  <= bus.job_data;
                pend_min_q   <= bus.job_nonce_min;
                pend_max_q   <= bus.job_nonce_max;
                pend_id_q    <= bus.job_id;
                pend_valid_q <= 1'b1;
            end else if (w_load_pend) begin
                pend_valid_q <= 1'b0;
            end

            if (state_q == S_START) begin
                run_cnt_q <= '0;
                budget_q  <= w_budget;
            end else if (state_q == S_RUN) begin
                run_cnt_q <= run_cnt_q + 40'd1;
            end

            if (state_q == S_CAPTURE) begin
                res_found_q <= w_hit;
                res_nonce_q <= w_hit ? bus.golden_nonce : 32'd0;
            end else if ((state_q == S_RUN) && (state_d == S_REPORT)) begin
                res_found_q <= 1'b0;
                res_nonce_q <= 32'd0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        w_load_job  = 1'b0;
        w_load_pend = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A job parked during the last REPORT handshake goes first.
                if (pend_valid_q) begin
                    w_load_pend = 1'b1;
                    state_d     = S_START;
                end else if (w_accept) begin
                    w_load_job = 1'b1;
                    state_d    = S_START;
                end
            end
            S_START: state_d = S_RUN;
            S_RUN: begin
                // Golden flag has priority over budget expiry.
                if ((run_cnt_q >= BLANK_W) && bus.is_golden_ticket) begin
                    state_d = S_CAPTURE;
                end else if (run_cnt_q == (budget_q - 40'd1)) begin
                    state_d = S_REPORT;
                end
            end
            S_CAPTURE: state_d = S_REPORT;
            S_REPORT: begin
                if (bus.res_ready) begin
                    if (pend_valid_q) begin
                        w_load_pend = 1'b1;
                        state_d     = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        bus.job_ready   = ~pend_valid_q;
        bus.midstate_vw = act_mid_q;
        bus.work_data   = act_data_q;
        bus.nonce_min   = act_min_q;
        bus.nonce_max   = act_max_q;
        bus.core_reset  = (state_q == S_START);
        bus.res_valid   = (state_q == S_REPORT);
        bus.res_found   = res_found_q;
        bus.res_nonce   = res_nonce_q;
        bus.res_job_id  = act_id_q;
        bus.busy        = (state_q != S_IDLE);
    end

endmodule
`default_nettype wire
